// File: rtl/pwm_bank_pkg.sv
// pwm_bank_pkg: shared definitions for the PWM bank.
//   mode_t  - counting mode held in the ctrl register (bit0)
//   dir_t   - timebase counting direction
//   ADDR_*  - register map offsets relative to CHANNELS
//             (duty[n] lives at n, period at CHANNELS, ctrl at CHANNELS+1)
package pwm_bank_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTRE = 1'b1
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int unsigned ADDR_PERIOD_OFS = 0;
  localparam int unsigned ADDR_CTRL_OFS   = 1;

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: shared counter for the PWM bank.
//   clk, rst       - clock, asynchronous active-high reset
//   enable         - 0 holds count at 0, direction up, sync low
//   period_shadow  - shadow period P, loaded into the active copy on load
//   mode_shadow    - shadow mode bit (0 edge, 1 centre)
//   count          - current timebase value
//   load           - combinational strobe: active registers take shadow
//                    values on this edge (period boundary, or disabled)
//   sync           - registered one-cycle pulse at the start of each period
module pwm_timebase
  import pwm_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] period_shadow,
  input  logic             mode_shadow,
  output logic [WIDTH-1:0] count,
  output logic             load,
  output logic             sync
);

  logic [WIDTH-1:0] period_act;
  mode_t            mode_act;
  dir_t             dir, dir_next;
  logic [WIDTH-1:0] count_next;
  logic             wrap;

  // A period boundary is any step that returns the count to 0; this covers
  // P = 0 in both modes (count pinned at 0, boundary every cycle).
  always_comb begin
    count_next = count;
    dir_next   = dir;
    if (mode_act == MODE_EDGE) begin
      count_next = (count >= period_act) ? '0 : count + 1'b1;
      dir_next   = DIR_UP;
    end else if (dir == DIR_UP) begin
      if (count >= period_act) begin
        count_next = (period_act == '0) ? '0 : period_act - 1'b1;
        dir_next   = DIR_DOWN;
      end else begin
        count_next = count + 1'b1;
      end
    end else begin
      count_next = (count == '0) ? '0 : count - 1'b1;
    end
    wrap = (count_next == '0);
    if (wrap) dir_next = DIR_UP;
    load = !enable || wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      dir        <= DIR_UP;
      period_act <= '1;
      mode_act   <= MODE_EDGE;
      sync       <= 1'b0;
    end else begin
      if (load) begin
        period_act <= period_shadow;
        mode_act   <= mode_t'(mode_shadow);
      end
      if (!enable) begin
        count <= '0;
        dir   <= DIR_UP;
      end else begin
        count <= count_next;
        dir   <= dir_next;
      end
      sync <= enable && (count == '0);
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator sharing one timebase.
//   clk, rst  - clock, asynchronous active-high reset
//   enable    - 0 holds timebase at 0 and drives outputs low
//   wr_en     - register write strobe
//   wr_addr   - 0..CHANNELS-1 duty[n], CHANNELS period, CHANNELS+1 ctrl
//   wr_data   - write data (ctrl uses bit0 = mode)
//   out       - registered PWM outputs, out[n] = (count < duty[n])
//   sync      - registered pulse at the start of each period
// Writes land in shadow registers; active copies reload only at a period
// boundary, so a period is never cut short or stretched by an update.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ADDR_W   = $clog2(CHANNELS + 2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] out,
  output logic                sync
);

  localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(CHANNELS + ADDR_PERIOD_OFS);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(CHANNELS + ADDR_CTRL_OFS);

  logic [WIDTH-1:0]    period_sh;
  mode_t               mode_sh;
  logic [WIDTH-1:0]    count;
  logic                load;
  logic [CHANNELS-1:0] out_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_sh <= '1;
      mode_sh   <= MODE_EDGE;
    end else if (wr_en) begin
      if (wr_addr == A_PERIOD) period_sh <= wr_data;
      if (wr_addr == A_CTRL)   mode_sh   <= mode_t'(wr_data[0]);
    end
  end

  pwm_timebase #(
    .WIDTH(WIDTH)
  ) u_timebase (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .period_shadow(period_sh),
    .mode_shadow  (mode_sh),
    .count        (count),
    .load         (load),
    .sync         (sync)
  );

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [WIDTH-1:0] duty_sh;
    logic [WIDTH-1:0] duty_act;

    // Active takes the pre-write shadow when a write coincides with load.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        duty_sh  <= '0;
        duty_act <= '0;
      end else begin
        if (load) duty_act <= duty_sh;
        if (wr_en && (wr_addr == ADDR_W'(n))) duty_sh <= wr_data;
      end
    end

    assign out_next[n] = enable && (count < duty_act);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= '0;
    else     out <= out_next;
  end

endmodule
